// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_pkg
// Description : Shared decode/execute constants for the MIPS32 integer pipe:
//               result-class (alusel) codes, operation (aluop) codes,
//               enable constants and the zero word. Also provides the
//               alusel/aluop pair validity check used by the execute ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_stage_pkg;

  // Result classes
  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;

  // Operation subtypes
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27;
  localparam logic [7:0] OP_SLL = 8'h7C;
  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_SRA = 8'h03;

  // Enable constants shared with decode
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // True only for the alusel/aluop combinations the execute stage implements.
  function automatic logic is_valid_op(input logic [2:0] alusel,
                                       input logic [7:0] aluop);
    logic ok;
    ok = 1'b0;
    case (alusel)
      RES_LOGIC: ok = (aluop == OP_AND) || (aluop == OP_OR) ||
                      (aluop == OP_XOR) || (aluop == OP_NOR);
      RES_SHIFT: ok = (aluop == OP_SLL) || (aluop == OP_SRL) ||
                      (aluop == OP_SRA);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage : ex_stage_pkg
`default_nettype wire

// File: rtl/ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_if
// Description : Bundle of the execute-stage bus: control (stall/flush), the
//               decoded operation from ID, forwarding outputs back to ID,
//               registered outputs to MEM and the retired-write counter.
//               master : decode / pipeline-control side
//               slave  : execute stage
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_stage_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
);
  logic               stall_i;
  logic               flush_i;
  logic [2:0]         alusel_i;
  logic [7:0]         aluop_i;
  logic [DATA_W-1:0]  reg1_i;
  logic [DATA_W-1:0]  reg2_i;
  logic [RADDR_W-1:0] waddr_i;
  logic               we_i;

  logic [RADDR_W-1:0] ex_waddr_o;
  logic               ex_we_o;
  logic [DATA_W-1:0]  ex_wdata_o;
  logic [RADDR_W-1:0] mem_waddr_o;
  logic               mem_we_o;
  logic [DATA_W-1:0]  mem_wdata_o;
  logic [31:0]        retired_o;

  modport master (
    output stall_i, flush_i, alusel_i, aluop_i, reg1_i, reg2_i, waddr_i, we_i,
    input  ex_waddr_o, ex_we_o, ex_wdata_o,
    input  mem_waddr_o, mem_we_o, mem_wdata_o, retired_o
  );

  modport slave (
    input  stall_i, flush_i, alusel_i, aluop_i, reg1_i, reg2_i, waddr_i, we_i,
    output ex_waddr_o, ex_we_o, ex_wdata_o,
    output mem_waddr_o, mem_we_o, mem_wdata_o, retired_o
  );
endinterface : ex_stage_if
`default_nettype wire

// File: rtl/ex_stage_alu.sv
`default_nettype none
// ============================================================================
// Module      : ex_alu
// Description : Combinational logic/shift unit of the execute stage.
//   i_alusel  : result class
//   i_aluop   : operation subtype
//   i_reg1    : operand 1 (shift amount for shifts, low 5 bits only)
//   i_reg2    : operand 2 (value shifted for shifts)
//   o_result  : operation result, zero for unsupported pairs
//   o_valid   : high when the alusel/aluop pair is supported
// Revision    : 1.0 - initial release
// ============================================================================
module ex_alu
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  wire logic [2:0]        i_alusel,
  input  wire logic [7:0]        i_aluop,
  input  wire logic [DATA_W-1:0] i_reg1,
  input  wire logic [DATA_W-1:0] i_reg2,
  output logic      [DATA_W-1:0] o_result,
  output logic                   o_valid
);

  logic [4:0] w_shamt;

  assign w_shamt = i_reg1[4:0];
  assign o_valid = is_valid_op(i_alusel, i_aluop);

  always_comb begin
    o_result = '0;
    case (i_alusel)
      RES_LOGIC: begin
        case (i_aluop)
          OP_AND:  o_result = i_reg1 & i_reg2;
          OP_OR:   o_result = i_reg1 | i_reg2;
          OP_XOR:  o_result = i_reg1 ^ i_reg2;
          OP_NOR:  o_result = ~(i_reg1 | i_reg2);
          default: o_result = '0;
        endcase
      end
      RES_SHIFT: begin
        case (i_aluop)
          OP_SLL:  o_result = i_reg2 << w_shamt;
          OP_SRL:  o_result = i_reg2 >> w_shamt;
          // Signed cast makes >>> replicate the operand's top bit.
          OP_SRA:  o_result = DATA_W'($signed(i_reg2) >>> w_shamt);
          default: o_result = '0;
        endcase
      end
      default: o_result = '0;
    endcase
  end

endmodule : ex_alu
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : Execute stage of the five-stage MIPS32 integer pipeline.
//               Holds the ID/EX and EX/MEM registers, evaluates logic and
//               shift operations, forwards the in-flight result to decode and
//               counts write-enabled results retired into EX/MEM.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : ex_stage_if slave port (stall/flush, ID inputs, ex_* forwarding,
//          mem_* registered outputs, retired_o counter)
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input wire logic clk,
  input wire logic rst,
  ex_stage_if.slave bus
);

  // ID/EX register
  logic [2:0]         r_alusel;
  logic [7:0]         r_aluop;
  logic [DATA_W-1:0]  r_reg1;
  logic [DATA_W-1:0]  r_reg2;
  logic [RADDR_W-1:0] r_waddr;
  logic               r_we;

  // EX/MEM register
  logic [RADDR_W-1:0] r_mem_waddr;
  logic               r_mem_we;
  logic [DATA_W-1:0]  r_mem_wdata;

  logic [31:0]        r_retired;

  logic [DATA_W-1:0]  w_result;
  logic               w_valid;
  logic               w_ex_we;

  ex_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_alusel (r_alusel),
    .i_aluop  (r_aluop),
    .i_reg1   (r_reg1),
    .i_reg2   (r_reg2),
    .o_result (w_result),
    .o_valid  (w_valid)
  );

  // Writes to $0 and unsupported operations are suppressed here so that
  // neither forwarding nor the memory stage ever sees them as writes.
  assign w_ex_we = r_we & w_valid & (r_waddr != '0);

  // Forwarding outputs depend only on ID/EX state, never on *_i.
  assign bus.ex_waddr_o  = r_waddr;
  assign bus.ex_we_o     = w_ex_we;
  assign bus.ex_wdata_o  = w_result;

  assign bus.mem_waddr_o = r_mem_waddr;
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_wdata_o = r_mem_wdata;
  assign bus.retired_o   = r_retired;

  // Pipeline registers: rst and flush both load bubbles, stall holds.
  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      r_alusel    <= RES_NOP;
      r_aluop     <= OP_NOP;
      r_reg1      <= '0;
      r_reg2      <= '0;
      r_waddr     <= '0;
      r_we        <= WriteDisable;
      r_mem_waddr <= '0;
      r_mem_we    <= WriteDisable;
      r_mem_wdata <= '0;
    end else if (!bus.stall_i) begin
      r_alusel    <= bus.alusel_i;
      r_aluop     <= bus.aluop_i;
      r_reg1      <= bus.reg1_i;
      r_reg2      <= bus.reg2_i;
      r_waddr     <= bus.waddr_i;
      r_we        <= bus.we_i;
      r_mem_waddr <= r_waddr;
      r_mem_we    <= w_ex_we;
      r_mem_wdata <= w_result;
    end
  end

  // Counts only real captures into EX/MEM; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= '0;
    end else if (!bus.flush_i && !bus.stall_i && w_ex_we) begin
      r_retired <= r_retired + 32'd1;
    end
  end

endmodule : ex_stage
`default_nettype wire

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS32 integer pipeline, sitting between instruction decode and memory access. It owns the ID/EX and EX/MEM pipeline registers and evaluates the logic and shift operations that decode emits. It returns the in-flight EX result to decode for forwarding and presents the registered result to the memory stage.

## Interface
Parameters:
- `DATA_W`, 32: register and operand width.
- `RADDR_W`, 5: register-file address width.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `stall_i`  in  1: hold both pipeline registers.
- `flush_i`  in  1: replace both pipeline registers with bubbles.
- `alusel_i`  in  3: operation class from decode.
- `aluop_i`  in  8: operation subtype from decode.
- `reg1_i`  in  DATA_W: source operand 1. For shifts this is the shift amount.
- `reg2_i`  in  DATA_W: source operand 2. For shifts this is the value being shifted.
- `waddr_i`  in  RADDR_W: destination register.
- `we_i`  in  1: destination write request.
- `ex_waddr_o`  out  RADDR_W: forwarding address back to decode (combinational).
- `ex_we_o`  out  1: forwarding write-enable back to decode (combinational).
- `ex_wdata_o`  out  DATA_W: forwarding data back to decode (combinational).
- `mem_waddr_o`  out  RADDR_W: registered destination to the memory stage.
- `mem_we_o`  out  1: registered write-enable to the memory stage.
- `mem_wdata_o`  out  DATA_W: registered result to the memory stage.
- `retired_o`  out  32: count of write-enabled results accepted into EX/MEM.

## Operation
- **ID/EX register.** Latches `alusel`, `aluop`, `reg1`, `reg2`, `waddr` and `we`.
  - A bubble is `alusel`=RES_NOP, `aluop`=OP_NOP, operands 0, `waddr` 0, `we` 0.
- **Result, computed combinationally from the ID/EX contents:**
  - RES_LOGIC with OR, AND, XOR or NOR: bitwise `reg1` op `reg2`.
  - RES_SHIFT with SLL: `reg2 << reg1[4:0]`. With SRL: logical right shift. With SRA: arithmetic right shift, sign-filling from `reg2[31]`.
  - Only `reg1[4:0]` is used as the shift amount; `reg1[31:5]` is ignored.
  - RES_NOP, and any unlisted alusel/aluop pair: result 0 and effective `we` forced to 0.
- **Effective write-enable.** `ex_we_o` = latched `we` AND the pair is valid AND latched `waddr` != 0.
  - Writes to $0 are never forwarded or propagated.
- **Forwarding outputs.** `ex_waddr_o` is the latched `waddr`; `ex_wdata_o` is the result.
- **EX/MEM register.** Captures `ex_waddr_o`, `ex_we_o` and `ex_wdata_o`.
- **Retired counter.** `retired_o` increments when EX/MEM captures a word with `ex_we_o`=1. It wraps from 0xFFFFFFFF to 0.
- **Priority on every edge:** `rst` > `flush_i` > `stall_i` > normal capture.
  - `rst`: both registers become bubbles, `retired_o` becomes 0.
  - `flush_i`: both registers become bubbles; the counter does not increment that cycle.
  - `stall_i`: both registers hold and the counter holds.
- **Reset values.** After `rst`, every output is 0: `mem_*`, `retired_o` and all `ex_*`.

## Timing
- Latency:
  - ID inputs presented at edge N appear on `ex_*_o` after edge N.
  - The same operation appears on `mem_*_o` after edge N+1.
- `ex_*_o` are purely combinational from the ID/EX register.
  - No path from `*_i` to `ex_*_o` within a cycle, so there is no combinational loop through decode forwarding.
- Stall held for K cycles: `ex_*_o` and `mem_*_o` stay constant for K cycles. Normal flow resumes on the first edge with `stall_i`=0.
- `flush_i` and `stall_i` asserted together: flush wins.
- `rst` asserted mid-stall or mid-flush: reset wins in that cycle.

## Structure
- Shared defines package holds:
  - alusel codes: RES_NOP 3'b000, RES_LOGIC 3'b001, RES_SHIFT 3'b010.
  - aluop codes: OP_NOP 8'h00, AND 8'h24, OR 8'h25, XOR 8'h26, NOR 8'h27, SLL 8'h7C, SRL 8'h02, SRA 8'h03.
  - Write/read enable constants and ZeroWord.
  - These are the same constants decode uses.
- One natural sub-module, `ex_alu`: a combinational result and validity function of alusel, aluop, reg1 and reg2.
- The pipeline registers and the counter stay in `ex_stage`.

## Test plan
- **ORI-style op.** Drive RES_LOGIC/OR, `reg1`=0x00001234, `reg2`=0x0000FF00, `waddr`=3, `we`=1.
  - Next cycle: `ex_wdata_o`=0x0000FF34, `ex_we_o`=1.
  - Following cycle: `mem_*` match and `retired_o`=1.
- **Arithmetic shift.** Drive SRA with `reg1`=0xFFFFFFE4 (amount 4), `reg2`=0x80000010.
  - Required: `ex_wdata_o`=0xF8000001.
  - SLL with the same amount and operands gives 0x00000100.
- **Write to $0 and invalid ops.**
  - NOR with `waddr`=0, `we`=1: `ex_we_o`=0, `retired_o` unchanged.
  - Alusel RES_SHIFT with aluop 0x24: result 0, `we` 0.
- **Stall.** Assert `stall_i` for 3 cycles while changing inputs every cycle.
  - All outputs stay frozen.
  - The first post-stall capture is the input present on the release edge.
- **Flush beats stall.**
  - `flush_i` together with `stall_i`: both stages hold bubbles next cycle (`ex_we_o`=0, `mem_we_o`=0).
  - `rst` mid-sequence: every output is 0 after one edge.
- **Counter wrap.** Force 2^32 - 1 valid writes (or preload via a force in the bench); the next valid write reads `retired_o`=0.
